regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (we3/a3/wd3) among NREQ writeback requesters using round-robin arbitration and a valid/ready handshake.
- Also keeps a busy scoreboard of destination registers with an in-flight write, so the decode stage can stall on read-after-write hazards.
- Sits between the execute/load units and the 32x16 register file. Its write-port outputs drive the register file directly.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- AW, 5, register address width (32 registers).
- DW, 16, register data width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  requester i has a write pending.
- req_ready  output  NREQ  one-hot or zero; requester i's write is accepted this cycle.
- req_addr  input  NREQ*AW  destination register, requester i in slice [i*AW +: AW].
- req_data  input  NREQ*DW  write data, requester i in slice [i*DW +: DW].
- wb_stall  input  1  when high, no grant is issued this cycle.
- rsv_valid  input  1  issue stage reserves a destination register.
- rsv_addr  input  AW  register to mark busy.
- q1_addr  input  AW  hazard query address, port 1.
- q2_addr  input  AW  hazard query address, port 2.
- q1_busy  output  1  q1_addr has an outstanding write.
- q2_busy  output  1  q2_addr has an outstanding write.
- we3  output  1  register file write enable (registered).
- a3  output  AW  register file write address (registered).
- wd3  output  DW  register file write data (registered).

Behaviour:
- Reset (rst_n low, asynchronous):
  - we3=0, a3=0, wd3=0.
  - All busy bits are 0.
  - The round-robin pointer last_grant is NREQ-1, so requester 0 has top priority first.
  - Reset asserted mid-transfer discards any accepted but not yet written data.
- Arbitration (combinational within the cycle):
  - If wb_stall=0, grant the first i with req_valid[i]=1, scanning from (last_grant+1) mod NREQ upward with wrap.
  - req_ready is one-hot at the granted index, otherwise all zero. If wb_stall=1 or no valid request, req_ready=0.
  - req_ready depends on req_valid. Requesters must not make valid depend on ready.
- Handshake:
  - A transfer occurs when req_valid[i] and req_ready[i] are both high.
  - A requester holds valid, addr and data stable until its transfer.
  - At most one transfer per cycle.
- Pointer update: last_grant loads the granted index only on a transfer. It is unchanged on idle or stall cycles.
- Write port, latency 1:
  - A transfer in cycle N gives we3=1, a3=addr, wd3=data in cycle N+1 for exactly one cycle.
  - With no transfer in cycle N, we3=0 in cycle N+1; a3 and wd3 hold their previous values.
- Address 0:
  - Transfers to r0 are accepted (ready asserted, pointer advances) but produce we3=0.
  - Reserve of r0 is ignored.
  - q*_busy for address 0 is always 0.
- Scoreboard (32 bits, bit 0 hardwired 0):
  - Set: rsv_valid=1 sets busy[rsv_addr] at the clock edge.
  - Clear: we3=1 clears busy[a3] at the edge ending the cycle in which we3 is high, i.e. the same edge at which the register file stores the data.
  - Set and clear of the same address on one edge: set wins (a newer producer exists).
  - Set and clear of different addresses on one edge: both take effect.
  - q1_busy = busy[q1_addr] and q2_busy = busy[q2_addr], combinational from registered state. No bypass: a query in the cycle we3 is high still returns 1.
- Back-to-back transfers on consecutive cycles give we3 high on consecutive cycles. Sustained throughput is 1 write per cycle.
- Clearing a busy bit that is not set, or reserving one already set, is legal and has no further effect (no counting).

Test Plan:
- Reset then a single write: req_valid=001, req_addr[0]=5, req_data[0]=16'hBEEF, wb_stall=0 -> req_ready=001 in the same cycle; next cycle we3=1, a3=5, wd3=BEEF; the following cycle we3=0.
- Fairness: all three valid continuously for 6 cycles -> grant order 0,1,2,0,1,2; we3 high for 6 consecutive cycles with the matching a3/wd3.
- Stall: all valid, wb_stall=1 for 3 cycles -> req_ready=000 and we3=0 throughout; last_grant unchanged; after release the next grant is the expected round-robin index.
- r0 write: requester 1 writes addr 0, data 16'h1234 -> req_ready[1]=1 and the pointer advances; next cycle we3=0.
- Scoreboard lifecycle: rsv_valid with rsv_addr=7 -> q1_busy=1 for q1_addr=7 from the next cycle; write to r7 accepted in cycle N -> q1_busy stays 1 in N+1 and reads 0 in N+2.
- Set-wins collision: busy[9]=1, we3=1 with a3=9, and rsv_valid with rsv_addr=9 in the same cycle -> q2_busy for addr 9 remains 1 afterwards. Then assert rst_n=0 asynchronously mid-cycle -> busy clear and we3=0 immediately.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus a busy
// scoreboard of destination registers that have a write still in flight.
//
// Handshake: requester i transfers when req_valid[i] && req_ready[i] in one
// cycle. req_ready is a combinational function of req_valid. A requester
// holds valid/addr/data stable until its transfer and must never make valid
// depend on ready. At most one transfer happens per cycle.
module regfile_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic               wb_stall,
   input  logic               rsv_valid,
   input  logic [AW-1:0]      rsv_addr,
   input  logic [AW-1:0]      q1_addr,
   input  logic [AW-1:0]      q2_addr,
   output logic               q1_busy,
   output logic               q2_busy,
   output logic               we3,
   output logic [AW-1:0]      a3,
   output logic [DW-1:0]      wd3
);

   localparam int GW   = $clog2(NREQ);
   localparam int NREG = 1 << AW;

   logic [GW-1:0]   last_grant_q, last_grant_d;
   logic [GW-1:0]   gnt_idx;
   logic [GW-1:0]   cand;
   logic            gnt_any;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;
   logic            we3_q, we3_d;
   logic [AW-1:0]   a3_q, a3_d;
   logic [DW-1:0]   wd3_q, wd3_d;
   logic [NREG-1:0] busy_q, busy_d;

   // Round-robin pick: first valid requester after the last granted one.
   always_comb begin
      gnt_any   = 1'b0;
      gnt_idx   = last_grant_q;
      cand      = last_grant_q;
      req_ready = '0;
      if (!wb_stall) begin
         for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_grant_q) + k) % NREQ);
            if (!gnt_any && req_valid[cand]) begin
               gnt_any = 1'b1;
               gnt_idx = cand;
            end
         end
      end
      if (gnt_any) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   // Address/data of the granted requester.
   always_comb begin
      sel_addr = req_addr[int'(gnt_idx)*AW +: AW];
      sel_data = req_data[int'(gnt_idx)*DW +: DW];
   end

   // Next-state: pointer, write port (r0 writes are swallowed), scoreboard.
   always_comb begin
      last_grant_d = gnt_any ? gnt_idx : last_grant_q;
      we3_d        = gnt_any && (sel_addr != '0);
      a3_d         = a3_q;
      wd3_d        = wd3_q;
      if (we3_d) begin
         a3_d  = sel_addr;
         wd3_d = sel_data;
      end
      busy_d = busy_q;
      // Clear first so a same-address reserve (newer producer) wins.
      if (we3_q) begin
         busy_d[a3_q] = 1'b0;
      end
      if (rsv_valid) begin
         busy_d[rsv_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // State registers; reset discards any accepted-but-unwritten data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= GW'(NREQ - 1);
         we3_q        <= 1'b0;
         a3_q         <= '0;
         wd3_q        <= '0;
         busy_q       <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         we3_q        <= we3_d;
         a3_q         <= a3_d;
         wd3_q        <= wd3_d;
         busy_q       <= busy_d;
      end
   end

   // Hazard queries read registered state only (no bypass).
   always_comb begin
      q1_busy = busy_q[q1_addr];
      q2_busy = busy_q[q2_addr];
   end

   assign we3 = we3_q;
   assign a3  = a3_q;
   assign wd3 = wd3_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: reference model of the round-robin pointer
// and busy scoreboard, expected writes queued at grant and popped when the
// write port should show them.
module tb_regfile_wb_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 5;
   localparam int DW   = 16;

   logic               clk;
   logic               rst_n;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_data;
   logic               wb_stall;
   logic               rsv_valid;
   logic [AW-1:0]      rsv_addr;
   logic [AW-1:0]      q1_addr;
   logic [AW-1:0]      q2_addr;
   logic               q1_busy;
   logic               q2_busy;
   logic               we3;
   logic [AW-1:0]      a3;
   logic [DW-1:0]      wd3;

   int n_tests = 0;
   int n_fail  = 0;

   logic [AW+DW-1:0] exp_q[$];
   bit               exp_we_now;
   logic [31:0]      m_busy;
   int               m_last;
   int               last_gnt;

   regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data),
      .wb_stall(wb_stall),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
      .q1_addr(q1_addr), .q2_addr(q2_addr),
      .q1_busy(q1_busy), .q2_busy(q2_busy),
      .we3(we3), .a3(a3), .wd3(wd3)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: sim time limit reached, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_we_now = 1'b0;
      m_busy     = '0;
      m_last     = NREQ - 1;
      last_gnt   = -1;
   endtask

   task automatic model_grant(output int g);
      g = -1;
      if (!wb_stall) begin
         for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (m_last + k) % NREQ;
            if (g < 0 && req_valid[i]) g = i;
         end
      end
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
      req_valid[i]         = 1'b1;
   endtask

   // One clock: check outputs at negedge, advance model, return at posedge+1.
   task automatic cycle();
      int               g;
      logic [AW+DW-1:0] e;
      logic [31:0]      nb;
      logic [AW-1:0]    ga;
      @(negedge clk);
      e = '0;
      if (exp_we_now) begin
         e = exp_q.pop_front();
         chk("we3", {31'd0, we3}, 32'd1);
         chk("a3", {27'd0, a3}, {27'd0, e[AW+DW-1:DW]});
         chk("wd3", {16'd0, wd3}, {16'd0, e[DW-1:0]});
      end else begin
         chk("we3_idle", {31'd0, we3}, 32'd0);
      end
      model_grant(g);
      chk("req_ready", {29'd0, req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
      chk("q1_busy", {31'd0, q1_busy}, {31'd0, m_busy[q1_addr]});
      chk("q2_busy", {31'd0, q2_busy}, {31'd0, m_busy[q2_addr]});
      nb = m_busy;
      if (exp_we_now) nb[e[AW+DW-1:DW]] = 1'b0;
      if (rsv_valid && rsv_addr != '0) nb[rsv_addr] = 1'b1;
      m_busy     = nb;
      exp_we_now = 1'b0;
      last_gnt   = g;
      if (g >= 0) begin
         m_last = g;
         ga     = req_addr[g*AW +: AW];
         if (ga != '0) begin
            exp_q.push_back({ga, req_data[g*DW +: DW]});
            exp_we_now = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      wb_stall  = 1'b0;
      rsv_valid = 1'b0;
      rsv_addr  = '0;
      q1_addr   = 5'd5;
      q2_addr   = 5'd9;
      do_reset();

      // Reset state
      chk("rst_we3", {31'd0, we3}, 32'd0);
      chk("rst_a3", {27'd0, a3}, 32'd0);
      chk("rst_wd3", {16'd0, wd3}, 32'd0);
      chk("rst_q1", {31'd0, q1_busy}, 32'd0);
      chk("rst_q2", {31'd0, q2_busy}, 32'd0);

      // Single write from requester 0
      set_req(0, 5'd5, 16'hBEEF);
      #1;
      chk("t1_ready", {29'd0, req_ready}, 32'b001);
      cycle();
      req_valid = '0;
      chk("t1_we3", {31'd0, we3}, 32'd1);
      chk("t1_a3", {27'd0, a3}, 32'd5);
      chk("t1_wd3", {16'd0, wd3}, 32'hBEEF);
      cycle();
      chk("t1_we3_off", {31'd0, we3}, 32'd0);
      cycle();

      // Fairness from reset: 0,1,2,0,1,2
      do_reset();
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), DW'($urandom_range(0, 16'hFFFF)));
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("fair_order", {29'd0, req_ready}, 32'd1 << (k % 3));
         cycle();
         if (last_gnt >= 0) set_req(last_gnt, AW'(10 + k), DW'($urandom_range(0, 16'hFFFF)));
      end
      req_valid = '0;
      cycle();
      cycle();

      // Stall: no grants, pointer frozen (last granted was 2)
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(20 + i), DW'($urandom_range(0, 16'hFFFF)));
      wb_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_ready", {29'd0, req_ready}, 32'd0);
         cycle();
         chk("stall_we3", {31'd0, we3}, 32'd0);
      end
      wb_stall = 1'b0;
      #1;
      chk("stall_release", {29'd0, req_ready}, 32'b001);
      cycle();
      req_valid = '0;
      cycle();
      cycle();

      // r0 write from requester 1 (pointer is at 0)
      set_req(1, 5'd0, 16'h1234);
      q1_addr   = 5'd0;
      rsv_valid = 1'b1;
      rsv_addr  = 5'd0;
      #1;
      chk("r0_ready", {29'd0, req_ready}, 32'b010);
      cycle();
      req_valid = '0;
      rsv_valid = 1'b0;
      chk("r0_we3", {31'd0, we3}, 32'd0);
      chk("r0_busy", {31'd0, q1_busy}, 32'd0);
      for (int i = 0; i < NREQ; i++) set_req(i, AW'(3 + i), DW'($urandom_range(0, 16'hFFFF)));
      #1;
      chk("r0_ptr", {29'd0, req_ready}, 32'b100);
      cycle();
      req_valid = '0;
      cycle();
      cycle();

      // Scoreboard lifecycle on r7
      q1_addr   = 5'd7;
      rsv_valid = 1'b1;
      rsv_addr  = 5'd7;
      cycle();
      rsv_valid = 1'b0;
      chk("sb_set", {31'd0, q1_busy}, 32'd1);
      set_req(0, 5'd7, 16'h0777);
      cycle();
      req_valid = '0;
      chk("sb_n1", {31'd0, q1_busy}, 32'd1);
      cycle();
      chk("sb_n2", {31'd0, q1_busy}, 32'd0);

      // Random traffic obeying hold-until-transfer
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && $urandom_range(0, 1) == 1)
               set_req(i, AW'($urandom_range(0, 31)), DW'($urandom_range(0, 16'hFFFF)));
         end
         wb_stall  = ($urandom_range(0, 3) == 0);
         rsv_valid = ($urandom_range(0, 2) == 0);
         rsv_addr  = AW'($urandom_range(0, 31));
         q1_addr   = AW'($urandom_range(0, 31));
         q2_addr   = AW'($urandom_range(0, 31));
         cycle();
         if (last_gnt >= 0) req_valid[last_gnt] = 1'b0;
      end
      req_valid = '0;
      wb_stall  = 1'b0;
      rsv_valid = 1'b0;
      cycle();
      cycle();

      // Set-wins collision on r9
      q2_addr   = 5'd9;
      rsv_valid = 1'b1;
      rsv_addr  = 5'd9;
      cycle();
      rsv_valid = 1'b0;
      set_req(0, 5'd9, 16'h0999);
      cycle();
      req_valid = '0;
      rsv_valid = 1'b1;
      rsv_addr  = 5'd9;
      chk("sw_we3", {31'd0, we3}, 32'd1);
      chk("sw_a3", {27'd0, a3}, 32'd9);
      cycle();
      rsv_valid = 1'b0;
      chk("sw_busy", {31'd0, q2_busy}, 32'd1);
      cycle();
      chk("sw_busy2", {31'd0, q2_busy}, 32'd1);

      // Asynchronous reset mid-cycle while a write is on the port
      set_req(0, 5'd12, 16'hCAFE);
      cycle();
      req_valid = '0;
      chk("ar_pre_we3", {31'd0, we3}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_we3", {31'd0, we3}, 32'd0);
      chk("ar_a3", {27'd0, a3}, 32'd0);
      chk("ar_busy9", {31'd0, q2_busy}, 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle();
      cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
